// File: rtl/dec_scan_sequencer_if.sv
// Bundled control/status signals of the scan sequencer.
// The bench drives through master; the sequencer uses slave.
interface dec_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         mask;
  logic               en;
  logic [1:0]         a;
  logic               busy;
  logic               wrap;

  modport master (
    output start, stop, dwell, mask,
    input  en, a, busy, wrap
  );

  modport slave (
    input  start, stop, dwell, mask,
    output en, a, busy, wrap
  );
endinterface

// File: rtl/dec_scan_sequencer.sv
// Round-robin scan of a 2:4 decoder: each enabled channel gets a dwell of en=1,
// optionally separated by blanking cycles, with stop and wrap handling.
module dec_scan_sequencer #(
  parameter int DWELL_W = 8,
  parameter int BLANK   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dec_scan_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_BLANKING
  } state_t;

  localparam logic [3:0] BLANK_LD  = 4'(BLANK);
  localparam bit         HAS_BLANK = (BLANK != 0);

  state_t             r_state, w_state_nx;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nx;
  logic [3:0]         r_bcnt, w_bcnt_nx;
  logic [1:0]         r_a, w_a_nx;
  logic               r_en, w_en_nx;
  logic               r_wrap, w_wrap_nx;
  logic               r_stop_pend, w_stop_pend_nx;

  logic [DWELL_W-1:0] w_dwell_ld;
  logic [1:0]         w_first_idx;
  logic [1:0]         w_adv_idx;
  logic               w_adv_found;
  logic               w_stop_eff;
  logic               w_do_adv;

  // Dwell of zero behaves as one; the counter counts down to 1, so it never wraps.
  assign w_dwell_ld = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign w_stop_eff = r_stop_pend | bus.stop;

  always_comb begin
    w_first_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bus.mask[3 - i]) w_first_idx = 2'(3 - i);
    end
  end

  // Circular search from a+1; offset 4 lands back on a itself (single channel).
  always_comb begin
    logic [1:0] cand;
    w_adv_found = 1'b0;
    w_adv_idx   = r_a;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = r_a + 2'(k);
      if (!w_adv_found && bus.mask[cand]) begin
        w_adv_found = 1'b1;
        w_adv_idx   = cand;
      end
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_bcnt_nx      = r_bcnt;
    w_a_nx         = r_a;
    w_en_nx        = r_en;
    w_wrap_nx      = 1'b0;
    w_do_adv       = 1'b0;
    w_stop_pend_nx = r_stop_pend | ((r_state != S_IDLE) & bus.stop);

    case (r_state)
      S_IDLE: begin
        w_en_nx = 1'b0;
        if (bus.start && !bus.stop && (bus.mask != 4'b0000)) begin
          w_state_nx = S_ACTIVE;
          w_a_nx     = w_first_idx;
          w_en_nx    = 1'b1;
          w_cnt_nx   = w_dwell_ld;
        end
      end
      S_ACTIVE: begin
        if (r_cnt > DWELL_W'(1)) begin
          w_cnt_nx = r_cnt - DWELL_W'(1);
        end else if (w_stop_eff) begin
          w_state_nx = S_IDLE;
          w_en_nx    = 1'b0;
        end else if (HAS_BLANK) begin
          w_state_nx = S_BLANKING;
          w_en_nx    = 1'b0;
          w_bcnt_nx  = BLANK_LD;
        end else begin
          w_do_adv = 1'b1;
        end
      end
      S_BLANKING: begin
        if (r_bcnt > 4'd1) begin
          w_bcnt_nx = r_bcnt - 4'd1;
        end else if (w_stop_eff) begin
          w_state_nx = S_IDLE;
          w_en_nx    = 1'b0;
        end else begin
          w_do_adv = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_en_nx    = 1'b0;
      end
    endcase

    if (w_do_adv) begin
      if (w_adv_found) begin
        w_state_nx = S_ACTIVE;
        w_a_nx     = w_adv_idx;
        w_en_nx    = 1'b1;
        w_cnt_nx   = w_dwell_ld;
        w_wrap_nx  = (w_adv_idx <= r_a);
      end else begin
        w_state_nx = S_IDLE;
        w_en_nx    = 1'b0;
      end
    end

    if (w_state_nx == S_IDLE) w_stop_pend_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bcnt      <= '0;
      r_a         <= '0;
      r_en        <= 1'b0;
      r_wrap      <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_bcnt      <= w_bcnt_nx;
      r_a         <= w_a_nx;
      r_en        <= w_en_nx;
      r_wrap      <= w_wrap_nx;
      r_stop_pend <= w_stop_pend_nx;
    end
  end

  assign bus.en   = r_en;
  assign bus.a    = r_a;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Scoreboard bench: scans are modelled as lists of dwell segments; a monitor
// measures segments on the DUT outputs and compares them in order.
module tb_dec_scan_sequencer;
  localparam int DW = 8;
  localparam int BL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec_scan_sequencer_if #(.DWELL_W(DW)) bus_if ();
  dec_scan_sequencer_if #(.DWELL_W(DW)) bus0_if ();

  dec_scan_sequencer #(.DWELL_W(DW), .BLANK(BL)) u_dut (
    .clk(clk), .rst(rst), .bus(bus_if)
  );

  dec_scan_sequencer #(.DWELL_W(DW), .BLANK(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0_if)
  );

  typedef struct {
    int a;
    int len;
    int wrap;
    int tail;   // 0: next channel follows, 1: idle right after dwell, 2: idle after blanking
    int gap;
  } seg_t;

  seg_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_on   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected segments from the channel list: ascending enabled channels, circular.
  task automatic model_scan(input logic [3:0] m, input int dwell, input int nseg,
                            input int last_tail, input int last_len, output int last_a);
    int   ch[$];
    int   n;
    int   len;
    int   prev;
    seg_t s;
    for (int i = 0; i < 4; i++) if (m[i]) ch.push_back(i);
    n    = ch.size();
    len  = (dwell == 0) ? 1 : dwell;
    prev = -1;
    for (int k = 0; k < nseg; k++) begin
      s.a    = ch[k % n];
      s.wrap = (k > 0 && s.a <= prev) ? 1 : 0;
      prev   = s.a;
      s.len  = (k == nseg - 1 && last_len > 0) ? last_len : len;
      s.tail = (k == nseg - 1) ? last_tail : 0;
      s.gap  = (s.tail == 1) ? 0 : BL;
      exp_q.push_back(s);
    end
    last_a = ch[(nseg - 1) % n];
  endtask

  // Monitor
  bit         m_open = 1'b0;
  bit         m_gap  = 1'b0;
  int         m_len, m_wrap, m_gcnt;
  int         m_a;

  task automatic close_seg(input int tail, input int gap);
    seg_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_seg: got a=%0d len=%0d, required no segment", m_a, m_len);
    end else begin
      e = exp_q.pop_front();
      check("seg_a", m_a, e.a);
      check("seg_len", m_len, e.len);
      check("seg_wrap", m_wrap, e.wrap);
      check("seg_tail", tail, e.tail);
      check("seg_gap", gap, e.gap);
    end
  endtask

  task automatic open_seg();
    m_open = 1'b1;
    m_gap  = 1'b0;
    m_a    = int'(bus_if.a);
    m_len  = 1;
    m_wrap = int'(bus_if.wrap);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (m_open) begin
        if (bus_if.en && int'(bus_if.a) == m_a && !bus_if.wrap) begin
          m_len++;
        end else if (bus_if.en) begin
          close_seg(0, 0);
          open_seg();
        end else if (bus_if.busy) begin
          m_open = 1'b0;
          m_gap  = 1'b1;
          m_gcnt = 1;
        end else begin
          m_open = 1'b0;
          close_seg(1, 0);
        end
      end else if (m_gap) begin
        if (bus_if.en) begin
          close_seg(0, m_gcnt);
          open_seg();
        end else if (bus_if.busy) begin
          m_gcnt++;
        end else begin
          m_gap = 1'b0;
          close_seg(2, m_gcnt);
        end
      end else if (bus_if.en) begin
        open_seg();
      end
    end
  end

  task automatic wait_idle(input string name);
    int t = 0;
    while (bus_if.busy === 1'b1 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, bus_if.busy, 0);
  endtask

  // mode 0: stop mid-dwell, 1: stop in blanking, 2: mask->0 in blanking, 3: reset mid-dwell
  task automatic run_scan(input logic [3:0] m, input int dwell, input int s_idx, input int mode);
    int len, per, c, o, tail, lastlen, last_a, waited;
    bit hold;
    len = (dwell == 0) ? 1 : dwell;
    per = len + BL;
    lastlen = 0;
    if (mode == 0) begin
      o = $urandom % (len - 1); c = s_idx * per + o; tail = 1;
    end else if (mode == 3) begin
      o = $urandom % len; c = s_idx * per + o; tail = 1; lastlen = o + 1;
    end else if (mode == 1) begin
      c = s_idx * per + len; tail = 2;
    end else begin
      c = s_idx * per + len + ($urandom % BL); tail = 2;
    end
    model_scan(m, dwell, s_idx + 1, tail, lastlen, last_a);
    if (mode == 3) last_a = 0;

    hold = ($urandom % 2) == 1;
    bus_if.mask  = m;
    bus_if.dwell = DW'(dwell);
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    waited = 0;
    if (hold && c >= 2) begin
      @(posedge clk); #1;
      waited = 1;
    end
    bus_if.start = 1'b0;
    repeat (c - waited) @(posedge clk);
    #1;
    case (mode)
      0, 1: begin
        bus_if.stop = 1'b1;
        @(posedge clk); #1;
        bus_if.stop = 1'b0;
      end
      2: begin
        bus_if.mask = 4'b0000;
        repeat (BL) @(posedge clk);
        #1;
      end
      default: begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_en", bus_if.en, 0);
        check("rst_a", bus_if.a, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_wrap", bus_if.wrap, 0);
      end
    endcase
    wait_idle("scan_end_timeout");
    check("idle_en", bus_if.en, 0);
    check("idle_a_hold", bus_if.a, last_a);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int m, d, s, md, len;
    rst = 1'b1;
    bus_if.start = 1'b0;  bus_if.stop = 1'b0;  bus_if.dwell = '0;  bus_if.mask = '0;
    bus0_if.start = 1'b0; bus0_if.stop = 1'b0; bus0_if.dwell = '0; bus0_if.mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_en", bus_if.en, 0);
    check("reset_a", bus_if.a, 0);
    check("reset_busy", bus_if.busy, 0);
    check("reset_wrap", bus_if.wrap, 0);
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1;

    // start with empty mask, then start together with stop: both stay idle
    bus_if.mask = 4'b0000; bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    check("start_mask0_busy", bus_if.busy, 0);
    check("start_mask0_en", bus_if.en, 0);
    bus_if.mask = 4'b1111; bus_if.start = 1'b1; bus_if.stop = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0; bus_if.stop = 1'b0;
    check("start_stop_busy", bus_if.busy, 0);
    check("start_stop_en", bus_if.en, 0);
    repeat (2) @(posedge clk);
    #1;

    run_scan(4'b1111, 3, 4, 0);
    run_scan(4'b1010, 1, 3, 1);
    run_scan(4'b1111, 0, 5, 1);
    run_scan(4'b0100, 255, 2, 0);
    run_scan(4'b1111, 4, 2, 0);
    run_scan(4'b1111, 2, 1, 2);
    run_scan(4'b0110, 5, 2, 3);

    for (int it = 0; it < 14; it++) begin
      m   = 1 + ($urandom % 15);
      d   = $urandom % 8;
      s   = $urandom % 7;
      md  = $urandom % 4;
      len = (d == 0) ? 1 : d;
      if (md == 0 && len < 2) md = 1;
      run_scan(4'(m), d, s, md);
    end

    // Zero-blanking build: en stays high while the channel steps 0,1,2,3,0,...
    bus0_if.mask = 4'b1111; bus0_if.dwell = DW'(2); bus0_if.start = 1'b1;
    @(posedge clk); #1;
    bus0_if.start = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      check("nb_en", bus0_if.en, 1);
      check("nb_a", bus0_if.a, (cyc / 2) % 4);
      check("nb_wrap", bus0_if.wrap, (cyc == 8) ? 1 : 0);
      @(posedge clk); #1;
    end
    bus0_if.stop = 1'b1;
    @(posedge clk); #1;
    bus0_if.stop = 1'b0;
    begin
      int t = 0;
      while (bus0_if.busy === 1'b1 && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
    end
    check("nb_idle_busy", bus0_if.busy, 0);
    check("nb_idle_a", bus0_if.a, 2);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
